// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// Handshake: req is a level that is only sampled while the responder is idle;
// ready is a one-cycle response pulse, and rdata/err are meaningful while ready=1.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory behind a fixed-latency request/response handshake,
// with alignment and range error detection.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_responder_if.slave    bus,
    output logic [1:0]        dbg_state_o
);

    localparam int unsigned CNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        rdata_q;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               accept;
    logic               enter_resp;
    logic               live_err;
    logic               acc_we;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_idx;
    logic [31:0]        acc_wdata;

    assign live_err = (bus.addr[1:0] != 2'b00) || ({1'b0, bus.addr} >= ADDR_LIMIT);
    assign accept   = (state_q == S_IDLE) && bus.req;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                // <= rather than == so a corrupted zero count cannot strand the FSM in WAIT
                if (cnt_q <= CNT_ONE) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With no wait states the access happens on the accepting edge, so it uses the live inputs.
    always_comb begin
        acc_we    = we_q;
        acc_err   = err_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (WAIT_CYCLES == 0) begin
            acc_we    = bus.we;
            acc_err   = live_err;
            acc_idx   = bus.addr[IDX_W+1:2];
            acc_wdata = bus.wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.we;
                idx_q   <= bus.addr[IDX_W+1:2];
                wdata_q <= bus.wdata;
                err_q   <= live_err;
            end
            if (enter_resp) begin
                if (acc_err)      rdata_q <= '0;
                else if (!acc_we) rdata_q <= mem_q[acc_idx];
            end
        end
    end

    // Storage is deliberately not reset; only the write strobe is gated by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && acc_we && !acc_err) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.ready   = (state_q == S_RESP);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.err     = (state_q == S_RESP) && err_q;
    assign bus.rdata   = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance under directed and random traffic,
// plus a WAIT_CYCLES=0 instance, both checked by a scoreboard against a memory model.
module tb_mem_responder;
  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  // {ready cycle[15:0], err, rdata[31:0]}
  logic [48:0] exp_q[$];
  logic [48:0] exp0_q[$];

  logic [31:0] mem_m [DEPTH];
  logic [31:0] mem0_m [DEPTH];
  logic [31:0] last_m;
  logic [31:0] last0_m;

  mem_responder_if bus();
  mem_responder_if bus0();

  mem_responder #(.WAIT_CYCLES(W), .DEPTH_WORDS(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .dbg_state_o(dbg_state0)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // reference model: returns {err, rdata} for a transaction and updates the model memory
  function automatic logic [32:0] predict(input bit sel0, input logic we,
                                          input logic [31:0] addr, input logic [31:0] wdata);
    logic e;
    longint unsigned a;
    a = longint'(addr);
    e = (addr % 4 != 0) || (a >= 4 * DEPTH);
    if (sel0) begin
      if (e) last0_m = 32'h0;
      else if (we) mem0_m[addr / 4] = wdata;
      else last0_m = mem0_m[addr / 4];
      return {e, last0_m};
    end else begin
      if (e) last_m = 32'h0;
      else if (we) mem_m[addr / 4] = wdata;
      else last_m = mem_m[addr / 4];
      return {e, last_m};
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // driver tasks: each starts and ends at a negedge with the DUT idle
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    logic [32:0] r;
    @(negedge clk);
    k = cyc;
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    r = predict(1'b0, we, addr, wdata);
    exp_q.push_back({16'(k + 1 + W), r});
    @(negedge clk);
    bus.req = 1'b0;
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    repeat (W + 1) @(negedge clk);
    chk("busy_back_idle", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic issue0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    logic [32:0] r;
    @(negedge clk);
    k = cyc;
    bus0.req = 1'b1; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata;
    r = predict(1'b1, we, addr, wdata);
    exp0_q.push_back({16'(k + 1), r});
    @(negedge clk);
    bus0.req = 1'b0;
    chk("w0_busy_resp", {31'b0, bus0.busy}, 32'd1);
    @(negedge clk);
    chk("w0_busy_idle", {31'b0, bus0.busy}, 32'd0);
  endtask

  task automatic back_to_back(input logic [31:0] addr);
    int k;
    logic [32:0] r;
    @(negedge clk);
    k = cyc;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = addr; bus.wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      r = predict(1'b0, 1'b0, addr, 32'h0);
      exp_q.push_back({16'(k + 1 + i * (W + 2) + W), r});
    end
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == W + 2 || j == 2 * (W + 2)) chk("b2b_gap_busy", {31'b0, bus.busy}, 32'd0);
      if (j == 2) chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
    end
    bus.req = 1'b0;
  endtask

  task automatic reset_abort(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = addr; bus.wdata = wdata;
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_m = 32'h0;
    last0_m = 32'h0;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_ready", {31'b0, bus.ready}, 32'd0);
    chk("abort_rdata", bus.rdata, 32'h0);
    repeat (W + 2) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      logic [48:0] e;
      if (bus.ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready at cycle %0d: actual=ready with rdata=%h err=%b required=no response",
                   cyc, bus.rdata, bus.err);
        end else begin
          e = exp_q.pop_front();
          if (16'(cyc) !== e[48:33] || bus.err !== e[32] || bus.rdata !== e[31:0]) begin
            bad++;
            $display("FAIL response: actual cycle=%0d err=%b rdata=%h required cycle=%0d err=%b rdata=%h",
                     cyc, bus.err, bus.rdata, e[48:33], e[32], e[31:0]);
          end
        end
      end else begin
        total++;
        if (bus.err !== 1'b0) begin
          bad++;
          $display("FAIL err_without_ready at cycle %0d: actual=%b required=0", cyc, bus.err);
        end
      end
      if (bus0.ready === 1'b1) begin
        total++;
        if (exp0_q.size() == 0) begin
          bad++;
          $display("FAIL w0_unexpected_ready at cycle %0d: actual=ready required=no response", cyc);
        end else begin
          e = exp0_q.pop_front();
          if (16'(cyc) !== e[48:33] || bus0.err !== e[32] || bus0.rdata !== e[31:0]) begin
            bad++;
            $display("FAIL w0_response: actual cycle=%0d err=%b rdata=%h required cycle=%0d err=%b rdata=%h",
                     cyc, bus0.err, bus0.rdata, e[48:33], e[32], e[31:0]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] a;
    int sel;
    rst = 1'b1;
    bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = 32'h0;  bus.wdata = 32'h0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
    last_m = 32'h0;
    last0_m = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", {31'b0, bus.ready}, 32'd0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_err", {31'b0, bus.err}, 32'd0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_state", {30'b0, dbg_state}, 32'd0);
    chk("w0_reset_busy", {31'b0, bus0.busy}, 32'd0);
    mon_en = 1'b1;

    // give the first 16 words defined contents
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom);

    issue(1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 32'h0);
    issue(1'b0, 32'h13, 32'h0);
    issue(1'b1, 32'h400, 32'h12345678);
    issue(1'b0, 32'h0, 32'h0);
    issue(1'b0, 32'hFFFFFFFC, 32'h0);

    reset_abort(32'h20, 32'hA5A5A5A5);
    issue(1'b0, 32'h20, 32'h0);

    back_to_back(32'h10);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, 15) * 4);
      else if (sel < 9) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else              a = 32'h400 + 32'($urandom_range(0, 1000) * 4);
      issue(1'($urandom_range(0, 1)), a, $urandom);
    end

    issue0(1'b1, 32'h8, 32'h11223344);
    issue0(1'b0, 32'h8, 32'h0);
    issue0(1'b0, 32'h9, 32'h0);
    issue0(1'b1, 32'h3FC, 32'hCAFEF00D);
    issue0(1'b0, 32'h3FC, 32'h0);

    for (int t = 0; t < 50 && (exp_q.size() != 0 || exp0_q.size() != 0); t++) @(negedge clk);
    chk("pending_responses", 32'(exp_q.size() + exp0_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Parameters
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait-state edges between request acceptance and the response (0 allowed).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the storage array (power of two).

Interface
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  level request from the initiator; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 rdata  output  32  registered read data.
REQ-010 ready  output  1  one-cycle response pulse.
REQ-011 busy  output  1  transaction in progress.
REQ-012 err  output  1  error flag, valid while ready=1.

Function
REQ-013 The block SHALL implement states IDLE, WAIT and RESP; busy SHALL be 0 in IDLE and 1 in WAIT and RESP.
REQ-014 In IDLE with req=1 at an edge, the block SHALL capture we, addr and wdata and SHALL evaluate the error condition. It SHALL load the wait counter with WAIT_CYCLES and go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-015 In WAIT, the counter SHALL decrement each edge; at the edge where it equals 1, the state SHALL move to RESP.
REQ-016 Counter width SHALL be $clog2(WAIT_CYCLES+1), minimum 1 bit; the counter SHALL never wrap below 0.
REQ-017 The storage access SHALL occur at the edge entering RESP, using the captured values (live inputs when WAIT_CYCLES=0).
  - Read: rdata <= mem[word index].
  - Write: mem[word index] <= wdata, with rdata unchanged.
REQ-018 The word index SHALL be addr[$clog2(DEPTH_WORDS)+1:2].
REQ-019 An error SHALL be flagged when addr[1:0] != 0 or addr >= 4*DEPTH_WORDS.
REQ-020 An error transaction SHALL NOT write memory; it SHALL set rdata to 0 and assert err=1 during RESP.
REQ-021 ready SHALL be 1 for exactly the one cycle spent in RESP; err SHALL be 0 whenever ready=0.
REQ-022 Latency: with acceptance at edge T, RESP (ready=1) SHALL hold during the cycle following edge T+WAIT_CYCLES.
REQ-023 RESP SHALL go to IDLE at the next edge unconditionally; req SHALL be ignored in WAIT and RESP.
REQ-024 req held high in IDLE SHALL start a new transaction; back-to-back accepts SHALL be spaced WAIT_CYCLES+2 edges apart.
REQ-025 rdata SHALL hold its value until the next read or error response.

Reset
REQ-026 Reset=1 at an edge SHALL force state=IDLE, counter=0, ready=0, err=0, busy=0 and rdata=0, and SHALL take priority over req.
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 Reset asserted during WAIT SHALL abort the transaction: no memory write, no ready pulse.
REQ-029 Reset during RESP SHALL clear ready at that edge; a write already committed on entry to RESP SHALL remain.

Verification (WAIT_CYCLES=2 unless stated)
REQ-030 Write 0xDEADBEEF to 0x10, then read 0x10 -> each ready pulse occurs in the cycle after edge T+2; read returns rdata=0xDEADBEEF, err=0.
REQ-031 Read at misaligned address 0x13 -> one ready pulse with err=1, rdata=0x00000000, busy=1 for 3 cycles.
REQ-032 Write 0x12345678 to 0x400 (out of range, DEPTH_WORDS=256), then read 0x000 -> the write gets err=1; the read returns the prior contents of word 0 with err=0.
REQ-033 Write 0xA5A5A5A5 to 0x20 with Reset pulsed one cycle after acceptance -> no ready, busy=0 after reset; a later read of 0x20 returns the pre-write value.
REQ-034 req held high with we=0 for 12 cycles -> ready pulses exactly every 4 cycles, busy low for one cycle between transactions.
REQ-035 WAIT_CYCLES=0 build: read accepted at edge T -> ready=1 in the cycle after edge T, busy high for one cycle only.
